// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider for divw/divwu: one quotient bit per cycle.
// Condition field layout: crf[3]=lt, crf[2]=gt, crf[1]=eq, crf[0]=ov.
module div_seq #(
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              uns,
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    output logic              busy,
    output logic              valid,
    output logic [DWIDTH-1:0] quot,
    output logic [DWIDTH-1:0] rem,
    output logic [3:0]        crf
);

    localparam int unsigned CW = $clog2(DWIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DWIDTH-1:0] r_a;
    logic [DWIDTH-1:0] r_b;
    logic              r_uns;
    logic [DWIDTH-1:0] r_dvd;
    logic [DWIDTH-1:0] r_dvs;
    logic [DWIDTH-1:0] r_prem;
    logic [CW-1:0]     r_cnt;
    logic              r_qneg;
    logic              r_rneg;
    logic [DWIDTH-1:0] r_quot;
    logic [DWIDTH-1:0] r_rem;
    logic [3:0]        r_crf;

    logic              w_exc;
    logic              w_last;
    logic              w_ge;
    logic [DWIDTH:0]   w_trial;
    logic [DWIDTH-1:0] w_diff;
    logic [DWIDTH-1:0] w_abs_a;
    logic [DWIDTH-1:0] w_abs_b;
    logic [DWIDTH-1:0] w_quot_fix;
    logic [DWIDTH-1:0] w_rem_fix;
    logic [3:0]        w_crf_fix;

    // Divide-by-zero always traps; the MIN/-1 overflow only exists in signed mode.
    assign w_exc = (r_b == '0) ||
                   (!r_uns && (r_a == {1'b1, {(DWIDTH-1){1'b0}}}) && (r_b == '1));

    assign w_abs_a = (!r_uns && r_a[DWIDTH-1]) ? -r_a : r_a;
    assign w_abs_b = (!r_uns && r_b[DWIDTH-1]) ? -r_b : r_b;

    // Shifted partial remainder needs one extra bit; the compare is the
    // DWIDTH+1-bit trial subtraction, and the low bits of the difference suffice
    // because an accepted difference is always smaller than the divisor.
    assign w_trial = {r_prem, r_dvd[DWIDTH-1]};
    assign w_ge    = (w_trial >= {1'b0, r_dvs});
    assign w_diff  = w_trial[DWIDTH-1:0] - r_dvs;
    assign w_last  = (r_cnt == CW'(DWIDTH-1));

    assign w_quot_fix = r_qneg ? -r_dvd : r_dvd;
    assign w_rem_fix  = r_rneg ? -r_prem : r_prem;

    always_comb begin
        w_crf_fix = 4'b0000;
        if (w_quot_fix[DWIDTH-1]) begin
            w_crf_fix[3] = 1'b1;
        end else if (w_quot_fix == '0) begin
            w_crf_fix[1] = 1'b1;
        end else begin
            w_crf_fix[2] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b1;
        valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = S_PREP;
                end
            end
            S_PREP: begin
                w_next = w_exc ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (w_last) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                valid  = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_uns  <= 1'b0;
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_prem <= '0;
            r_cnt  <= '0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
            r_quot <= '0;
            r_rem  <= '0;
            r_crf  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_uns <= uns;
                    end
                end
                S_PREP: begin
                    if (w_exc) begin
                        r_quot <= '0;
                        r_rem  <= '0;
                        r_crf  <= 4'b0011;
                    end else begin
                        r_dvd  <= w_abs_a;
                        r_dvs  <= w_abs_b;
                        r_qneg <= !r_uns && (r_a[DWIDTH-1] ^ r_b[DWIDTH-1]);
                        r_rneg <= !r_uns && r_a[DWIDTH-1];
                        r_prem <= '0;
                        r_cnt  <= '0;
                    end
                end
                S_CALC: begin
                    // Dividend register doubles as the quotient shift register.
                    r_prem <= w_ge ? w_diff : w_trial[DWIDTH-1:0];
                    r_dvd  <= {r_dvd[DWIDTH-2:0], w_ge};
                    r_cnt  <= r_cnt + CW'(1);
                end
                S_FIX: begin
                    r_quot <= w_quot_fix;
                    r_rem  <= w_rem_fix;
                    r_crf  <= w_crf_fix;
                end
                default: begin
                end
            endcase
        end
    end

    assign quot = r_quot;
    assign rem  = r_rem;
    assign crf  = r_crf;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: stimulus pushes expected results, a monitor
// pops and compares on every valid pulse, including the start-to-valid latency.
module tb_div_seq;

    localparam logic [3:0] C_LT  = 4'b1000;
    localparam logic [3:0] C_GT  = 4'b0100;
    localparam logic [3:0] C_EQ  = 4'b0010;
    localparam logic [3:0] C_EXC = 4'b0011;

    logic        clk;
    logic        reset;
    logic        start;
    logic        uns;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        valid;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [3:0]  crf;

    div_seq #(.DWIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .uns   (uns),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .valid (valid),
        .quot  (quot),
        .rem   (rem),
        .crf   (crf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic [3:0]  c;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [3:0] crf_of(input logic [31:0] q);
        if (q[31]) return C_LT;
        if (q == 32'd0) return C_EQ;
        return C_GT;
    endfunction

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_valid: got valid=1 expected no pending result (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                check("quot", quot, mon_e.q);
                check("rem", rem, mon_e.r);
                check("crf", {28'd0, crf}, {28'd0, mon_e.c});
                check("latency", 32'(cyc - mon_e.t0), 32'(mon_e.lat));
            end
        end
    end

    task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v, input logic tu,
                         input logic push, input logic [31:0] eq_v, input logic [31:0] er_v,
                         input logic [3:0] ec_v, input int el);
        int   guard;
        exp_t x;
        guard = 0;
        while (busy === 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (busy !== 1'b0) begin
            n_checks++;
            n_err++;
            $display("FAIL issue_timeout: got busy=%b expected 0", busy);
        end
        a     = ta;
        b     = tb_v;
        uns   = tu;
        start = 1'b1;
        if (push) begin
            x.q   = eq_v;
            x.r   = er_v;
            x.c   = ec_v;
            x.lat = el;
            x.t0  = cyc;
            sb.push_back(x);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(sb.size() == 0 && busy === 1'b0) && guard < 100);
        if (!(sb.size() == 0 && busy === 1'b0)) begin
            n_checks++;
            n_err++;
            $display("FAIL result_timeout: got pending=%0d expected 0", sb.size());
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb, eq_v, er_v;
        logic        ru;
        int          sa, sbv;
        int          guard;

        reset = 1'b1;
        start = 1'b0;
        uns   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_quot", quot, 32'd0);
        check("rst_rem", rem, 32'd0);
        check("rst_crf", {28'd0, crf}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Abort in CALC: no result may appear; outputs remain cleared.
        issue(32'd100, 32'd7, 1'b0, 1'b0, '0, '0, '0, 0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_valid", {31'd0, valid}, 32'd0);
        check("abort_quot", quot, 32'd0);
        check("abort_rem", rem, 32'd0);
        repeat (40) @(negedge clk);
        issue(32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 32'd2, C_GT, 35);
        wait_idle();

        // Sign combinations.
        issue(-32'sd7, 32'd2, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, C_LT, 35); wait_idle();
        issue(32'd7, -32'sd2, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd1, C_LT, 35);        wait_idle();
        issue(-32'sd7, -32'sd2, 1'b0, 1'b1, 32'd3, 32'hFFFF_FFFF, C_GT, 35);       wait_idle();
        issue(32'd0, 32'd5, 1'b0, 1'b1, 32'd0, 32'd0, C_EQ, 35);                   wait_idle();

        // Unsigned boundaries.
        issue(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd0, C_LT, 35);    wait_idle();
        issue(32'hFFFF_FFFF, 32'h1_0000, 1'b1, 1'b1, 32'hFFFF, 32'hFFFF, C_GT, 35); wait_idle();
        issue(32'd3, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0, 32'd3, C_EQ, 35);            wait_idle();

        // Exceptions and the unsigned counterpart of the overflow operands.
        issue(32'd5, 32'd0, 1'b0, 1'b1, 32'd0, 32'd0, C_EXC, 2);                          wait_idle();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0, 32'd0, C_EXC, 2);          wait_idle();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0, 32'h8000_0000, C_EQ, 35);  wait_idle();
        issue(32'd5, 32'd0, 1'b1, 1'b1, 32'd0, 32'd0, C_EXC, 2);                          wait_idle();

        // start while busy (cycles 3 and 20 of the operation) is ignored.
        issue(32'd1000, 32'd10, 1'b0, 1'b1, 32'd100, 32'd0, C_GT, 35);
        repeat (2) @(negedge clk);
        a = 32'd5; b = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        a = 32'd7; b = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // start in the valid cycle is ignored; the next cycle accepts.
        issue(32'd50, 32'd5, 1'b0, 1'b1, 32'd10, 32'd0, C_GT, 35);
        guard = 0;
        while (valid !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        a = 32'd9; b = 32'd4; uns = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("valid_cycle_start_ignored", {31'd0, busy}, 32'd0);
        issue(32'd9, 32'd3, 1'b0, 1'b1, 32'd3, 32'd0, C_GT, 35);
        wait_idle();

        // Results hold through idle cycles.
        repeat (10) @(negedge clk);
        check("hold_quot", quot, 32'd3);
        check("hold_rem", rem, 32'd0);
        check("hold_crf", {28'd0, crf}, {28'd0, C_GT});
        check("hold_busy", {31'd0, busy}, 32'd0);

        // Random operands against a truncating-division reference.
        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            ru = 1'($urandom_range(0, 1));
            if (rb == 32'd0) rb = 32'd1;
            if (!ru && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd2;
            if (ru) begin
                eq_v = ra / rb;
                er_v = ra % rb;
            end else begin
                sa   = ra;
                sbv  = rb;
                eq_v = 32'(sa / sbv);
                er_v = 32'(sa % sbv);
            end
            issue(ra, rb, ru, 1'b1, eq_v, er_v, crf_of(eq_v), 35);
            wait_idle();
        end

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
